// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM transmit path: sequencer states, default
// geometry and the midscale code. Also used by the decimator benches.
package pdm_pkg;

    localparam int PDM_WIDTH = 8;
    localparam int PDM_OSR   = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pdm_state_t;

    // Offset-binary zero: the code that gives 50% ones density.
    function automatic logic [31:0] midscale(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/pdm_fifo2.sv
// Two-entry sample buffer. Pushes are dropped when full and pops are dropped
// when empty, so a simultaneous push/pop keeps the count and the order.
module pdm_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [1:0]       o_count,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && (r_count != 2'd2);
    assign w_do_pop  = i_pop  && (r_count != 2'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

endmodule

// File: rtl/pdm_modulator.sv
// First-order delta-sigma PCM-to-PDM modulator with a sample sequencer that
// holds each buffered sample for OSR clocks.
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int WIDTH = PDM_WIDTH,
    parameter int OSR   = PDM_OSR
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [WIDTH-1:0]        DIN,
    input  logic                    DIN_VALID,
    output logic                    DIN_READY,
    output logic                    OUT,
    output logic                    UNDERRUN,
    output pdm_state_t              o_dbg_state,
    output logic [$clog2(OSR)-1:0]  o_dbg_phase,
    output logic [1:0]              o_dbg_count,
    output logic [WIDTH-1:0]        o_dbg_cur
);

    localparam int PW = $clog2(OSR);
    localparam logic [WIDTH-1:0] MID = WIDTH'(midscale(WIDTH));
    localparam logic [PW-1:0] LAST_PHASE = PW'(OSR - 1);

    // Handshake: a sample transfers on any rising edge where DIN_VALID and
    // DIN_READY are both high; DIN_READY depends only on the buffer count.
    pdm_state_t       r_state;
    logic [PW-1:0]    r_phase;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_acc;
    logic             r_out;
    logic             r_underrun;

    pdm_state_t       w_next_state;
    logic [PW-1:0]    w_next_phase;
    logic             w_pop;
    logic             w_load;
    logic             w_underrun;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH:0]   w_sum;
    logic [1:0]       w_count;
    logic [WIDTH-1:0] w_fifo_dout;
    logic             w_push;

    assign DIN_READY = (w_count != 2'd2);
    assign w_push    = DIN_VALID && DIN_READY;

    pdm_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (DIN),
        .o_count (w_count),
        .o_dout  (w_fifo_dout)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_phase = r_phase;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_underrun   = 1'b0;
        w_x          = MID;
        case (r_state)
            ST_IDLE: begin
                if (EN && (w_count != 2'd0)) begin
                    w_pop        = 1'b1;
                    w_load       = 1'b1;
                    w_next_phase = '0;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_x = r_cur;
                if (r_phase == LAST_PHASE) begin
                    w_next_phase = '0;
                    if (!EN) begin
                        w_next_state = ST_IDLE;
                    end else if (w_count != 2'd0) begin
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        // Empty boundary: keep repeating the last sample.
                        w_underrun = 1'b1;
                    end
                end else begin
                    w_next_phase = r_phase + 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_sum = {1'b0, r_acc} + {1'b0, w_x};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_cur      <= '0;
            r_acc      <= '0;
            r_out      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_phase    <= w_next_phase;
            r_underrun <= w_underrun;
            if (w_load) begin
                r_cur <= w_fifo_dout;
            end
            // The accumulator carries across state changes so density stays exact.
            r_acc <= w_sum[WIDTH-1:0];
            r_out <= w_sum[WIDTH];
        end
    end

    assign OUT         = r_out;
    assign UNDERRUN    = r_underrun;
    assign o_dbg_state = r_state;
    assign o_dbg_phase = r_phase;
    assign o_dbg_count = w_count;
    assign o_dbg_cur   = r_cur;

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed bench for pdm_modulator: level table plus idle, backpressure,
// underrun, stop and mid-sample reset sequences.
module tb_pdm_modulator;
    import pdm_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic       DIN_VALID = 1'b0;
    logic       DIN_READY;
    logic       OUT;
    logic       UNDERRUN;
    pdm_state_t dbg_state;
    logic [5:0] dbg_phase;
    logic [1:0] dbg_count;
    logic [7:0] dbg_cur;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] level;
        int         exp_ones;
    } vec_t;

    vec_t vecs [6];

    pdm_modulator #(.WIDTH(8), .OSR(64)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .DIN         (DIN),
        .DIN_VALID   (DIN_VALID),
        .DIN_READY   (DIN_READY),
        .OUT         (OUT),
        .UNDERRUN    (UNDERRUN),
        .o_dbg_state (dbg_state),
        .o_dbg_phase (dbg_phase),
        .o_dbg_count (dbg_count),
        .o_dbg_cur   (dbg_cur)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        EN = 1'b0;
        DIN_VALID = 1'b0;
        DIN = 8'h00;
        #1;
        tick();
        tick();
        RST = 1'b1;
    endtask

    // Push A, B, C back to back with EN=1 from an empty IDLE; count is 2
    // afterwards and A has been in cur for one edge.
    task automatic push_three(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        EN = 1'b1;
        DIN = a;
        DIN_VALID = 1'b1;
        tick();
        DIN = b;
        tick();
        DIN = c;
        tick();
        DIN_VALID = 1'b0;
    endtask

    task automatic run_level(input logic [7:0] level, input int exp_ones);
        int ones;
        int unds;
        ones = 0;
        unds = 0;
        do_reset();
        EN = 1'b1;
        DIN = level;
        DIN_VALID = 1'b1;
        tick();
        check("lvl_count_after_push", 32'(dbg_count), 32'd1);
        tick();
        check("lvl_cur_loaded", 32'(dbg_cur), 32'(level));
        check("lvl_state_run", 32'(dbg_state), 32'(ST_RUN));
        for (int i = 0; i < 256; i++) begin
            tick();
            ones += int'(OUT);
            unds += int'(UNDERRUN);
        end
        check($sformatf("lvl_ones_%02h", level), 32'(ones), 32'(exp_ones));
        check("lvl_no_underrun", 32'(unds), 32'd0);
        DIN_VALID = 1'b0;
    endtask

    initial begin
        int ones;
        int unds;
        int bad;

        vecs[0] = '{level: 8'h40, exp_ones: 64};
        vecs[1] = '{level: 8'h00, exp_ones: 0};
        vecs[2] = '{level: 8'hFF, exp_ones: 255};
        vecs[3] = '{level: 8'hC0, exp_ones: 192};
        vecs[4] = '{level: 8'h80, exp_ones: 128};
        vecs[5] = '{level: 8'h01, exp_ones: 1};

        // Reset state and idle pattern
        RST = 1'b0;
        #1;
        check("rst_out", 32'(OUT), 32'd0);
        check("rst_underrun", 32'(UNDERRUN), 32'd0);
        check("rst_ready", 32'(DIN_READY), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_phase", 32'(dbg_phase), 32'd0);
        do_reset();
        ones = 0;
        unds = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("idle_out_%0d", i), 32'(OUT), 32'(i % 2));
            ones += int'(OUT);
            unds += int'(UNDERRUN);
            if (DIN_READY !== 1'b1) bad++;
        end
        check("idle_ones", 32'(ones), 32'd8);
        check("idle_underrun", 32'(unds), 32'd0);
        check("idle_ready_low_cycles", 32'(bad), 32'd0);

        // Constant levels
        for (int v = 0; v < 6; v++) begin
            run_level(vecs[v].level, vecs[v].exp_ones);
        end

        // Backpressure with DIN_VALID high at reset release, EN=0
        RST = 1'b0;
        EN = 1'b0;
        DIN = 8'h11;
        DIN_VALID = 1'b1;
        #1;
        tick();
        tick();
        check("bp_reset_ignores_push", 32'(dbg_count), 32'd0);
        RST = 1'b1;
        check("bp_ready0", 32'(DIN_READY), 32'd1);
        tick();
        DIN = 8'h22;
        check("bp_ready1", 32'(DIN_READY), 32'd1);
        check("bp_count1", 32'(dbg_count), 32'd1);
        tick();
        DIN = 8'h33;
        check("bp_ready_drop", 32'(DIN_READY), 32'd0);
        check("bp_count2", 32'(dbg_count), 32'd2);
        repeat (3) tick();
        check("bp_still_full", 32'(dbg_count), 32'd2);
        check("bp_still_idle", 32'(dbg_state), 32'(ST_IDLE));
        EN = 1'b1;
        tick();
        check("bp_cur_a", 32'(dbg_cur), 32'h11);
        check("bp_ready_back", 32'(DIN_READY), 32'd1);
        tick();
        DIN_VALID = 1'b0;
        check("bp_third_accepted", 32'(dbg_count), 32'd2);
        repeat (62) tick();
        check("bp_cur_a_held", 32'(dbg_cur), 32'h11);
        tick();
        check("bp_cur_b", 32'(dbg_cur), 32'h22);
        repeat (63) tick();
        check("bp_cur_b_held", 32'(dbg_cur), 32'h22);
        tick();
        check("bp_cur_c", 32'(dbg_cur), 32'h33);
        check("bp_empty", 32'(dbg_count), 32'd0);
        repeat (64) tick();
        check("bp_underrun_at_end", 32'(UNDERRUN), 32'd1);
        check("bp_cur_repeat", 32'(dbg_cur), 32'h33);
        tick();
        check("bp_underrun_pulse", 32'(UNDERRUN), 32'd0);

        // Underrun: single sample then starve
        do_reset();
        EN = 1'b1;
        DIN = 8'hC0;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        tick();
        ones = 0;
        unds = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            ones += int'(OUT);
            unds += int'(UNDERRUN);
            if (UNDERRUN !== ((i % 64) == 63)) bad++;
        end
        check("und_ones", 32'(ones), 32'd192);
        check("und_pulses", 32'(unds), 32'd4);
        check("und_pulse_timing_errs", 32'(bad), 32'd0);
        check("und_state_run", 32'(dbg_state), 32'(ST_RUN));

        // Stop mid-sample
        do_reset();
        push_three(8'h40, 8'h80, 8'h20);
        check("stop_count2", 32'(dbg_count), 32'd2);
        repeat (10) tick();
        EN = 1'b0;
        repeat (52) tick();
        check("stop_still_run", 32'(dbg_state), 32'(ST_RUN));
        check("stop_cur_a", 32'(dbg_cur), 32'h40);
        tick();
        check("stop_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("stop_count_kept", 32'(dbg_count), 32'd2);
        check("stop_no_underrun", 32'(UNDERRUN), 32'd0);
        ones = 0;
        unds = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            ones += int'(OUT);
            unds += int'(UNDERRUN);
        end
        check("stop_mid_ones", 32'(ones), 32'd128);
        check("stop_mid_underrun", 32'(unds), 32'd0);
        check("stop_count_final", 32'(dbg_count), 32'd2);

        // Reset at phase 30 with a full buffer
        do_reset();
        push_three(8'hFF, 8'h10, 8'h20);
        repeat (29) tick();
        check("mr_phase30", 32'(dbg_phase), 32'd30);
        check("mr_count2", 32'(dbg_count), 32'd2);
        EN = 1'b0;
        RST = 1'b0;
        #1;
        check("mr_out0", 32'(OUT), 32'd0);
        check("mr_count0", 32'(dbg_count), 32'd0);
        check("mr_ready", 32'(DIN_READY), 32'd1);
        check("mr_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mr_cur", 32'(dbg_cur), 32'd0);
        tick();
        tick();
        RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("mr_idle_out_%0d", i), 32'(OUT), 32'(i % 2));
        end
        check("mr_count_after", 32'(dbg_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pdm_modulator.md
# pdm_modulator

First-order delta-sigma modulator that turns 8-bit PCM samples into a 1-bit pulse-density stream. It is the transmit-side counterpart of the `Filter` decimator, and it drives that block's `IN` port in loopback and system tests. Samples arrive over a valid/ready handshake into a 2-entry buffer. Each sample is held for `OSR` clocks while the modulator emits one bit per clock.

## Interface
- `WIDTH`, default 8: PCM sample width, unsigned offset-binary (0 = full negative, 2^WIDTH-1 = full positive).
- `OSR`, default 64: clocks per sample. Must be 2 or greater.
- `CLK` in 1: the single clock for the block.
- `RST` in 1: asynchronous, active-low reset.
- `EN` in 1: run enable. Sampled only at sample boundaries and in IDLE.
- `DIN` in `WIDTH`: PCM sample.
- `DIN_VALID` in 1: `DIN` is valid.
- `DIN_READY` out 1: buffer can accept a sample.
- `OUT` out 1: registered pulse-density bit.
- `UNDERRUN` out 1: one-cycle pulse when a sample boundary finds the buffer empty.

## Operation
- **Buffer:** 2-entry FIFO with a 2-bit count.
  - `DIN_READY = (count != 2)`. It is combinational from registers only and does not depend on `DIN_VALID`.
  - A push occurs on any rising edge where `DIN_VALID && DIN_READY`.
  - If a push and a pop happen in the same cycle, the count is unchanged and data order is preserved.
- **Registers:** state ∈ {IDLE, RUN}, phase counter (0..`OSR`-1), `cur` (current sample), `acc` (`WIDTH` bits).
- **IDLE:**
  - Modulator input is midscale, 2^(WIDTH-1). This produces an alternating 0,1,0,1 stream.
  - When `EN=1` and count>0: pop into `cur`, set phase to 0, go to RUN.
- **RUN:**
  - Modulator input is `cur`. Phase increments every clock.
  - At phase==`OSR`-1, phase wraps to 0, and then exactly one of the following applies:
    - `EN=0`: go to IDLE. No pop occurs and no `UNDERRUN` is raised.
    - Else, count>0: pop into `cur`.
    - Else (empty): keep `cur`, which repeats the last sample, and pulse `UNDERRUN` on the next cycle. Stay in RUN.
- **Modulator:** every clock, `sum = acc + x` at `WIDTH+1` bits, then `OUT <= sum[WIDTH]` and `acc <= sum[WIDTH-1:0]`.
  - `acc` is never cleared except by reset, including across IDLE/RUN transitions.
  - Ones density equals x/2^WIDTH exactly over any 2^WIDTH consecutive clocks with constant x.

## Timing
- **Reset (`RST`=0, asynchronous):**
  - state=IDLE, phase=0, `acc`=0, `cur`=0, count=0.
  - `OUT`=0, `UNDERRUN`=0, `DIN_READY`=1.
  - Handshakes while `RST`=0 are ignored.
  - A reset mid-sample discards the buffer and `cur` with no partial drain.
- **Latency:** a sample pushed at edge t into an empty buffer, in IDLE with `EN=1`, is loaded into `cur` at edge t+1. Its first modulated bit appears on `OUT` after edge t+2.
- **After reset with `EN=0`:** `OUT` reads 0,1,0,1,… with the first 0 produced at the first edge after reset release.
- **`UNDERRUN`:** registered, high for exactly one clock per empty boundary.
- **Sustained throughput:** one sample per `OSR` clocks. The producer sees `DIN_READY` low only while both entries are occupied.

## Structure
- Shared package `pdm_pkg`:
  - state enum {IDLE, RUN}
  - default `WIDTH`/`OSR` constants
  - `MIDSCALE` function of `WIDTH`
  - These are shared with `Filter` benches.
- One sub-module, `pdm_fifo2`: 2-entry FIFO exposing `push`, `pop`, `count`, `dout`.
- Sequencer and modulator live in `pdm_modulator`.

## Test plan
- **Reset, idle:** `EN`=0, no samples, 16 clocks → `OUT` = 0,1,0,…,1 (8 ones); `UNDERRUN` never high; `DIN_READY`=1.
- **Constant level:** `EN`=1, keep the buffer fed with 0x40. Over the 256 clocks starting 2 clocks after the first push → exactly 64 ones. With 0x00 → 0 ones. With 0xFF → 255 ones.
- **Backpressure:** `DIN_VALID` held high with 3 distinct samples at reset release, `EN`=0:
  - `DIN_READY` drops after 2 pushes.
  - Raise `EN`: the first pop re-asserts `DIN_READY` next cycle, the third sample is accepted, and samples are consumed in order, 64 clocks each.
- **Underrun:** feed one sample 0xC0, then stop → `UNDERRUN` pulses once at each 64-clock boundary. Ones density stays 3/4 (192 of every 256 clocks).
- **Stop:** drop `EN` mid-sample → current sample finishes its 64 clocks, then `OUT` reverts to midscale density and buffered samples remain (count unchanged).
- **Reset mid-operation:** assert `RST` at phase 30 with count=2 → `OUT`=0 immediately; after release, count=0, `DIN_READY`=1, and the idle pattern restarts with 0.
